// File: rtl/parity_frame_pkg.sv
// rtl/parity_frame_pkg.sv - state encoding and parity mode constants for the frame transmitter
package parity_frame_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_e;

    localparam logic MODE_EVEN = 1'b0;
    localparam logic MODE_ODD  = 1'b1;

endpackage

// File: rtl/parity_calc.sv
// rtl/parity_calc.sv - combinational even/odd parity of one data word
module parity_calc
    import parity_frame_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic [DATA_W-1:0] data_i,
    input  logic              mode_i,
    output logic              parity_o
);

    // Odd mode inverts the XOR-reduction so the total count of ones becomes odd.
    assign parity_o = (mode_i == MODE_ODD) ? ~^data_i :
                      (mode_i == MODE_EVEN) ? ^data_i : 1'b0;

endmodule

// File: rtl/parity_frame_tx.sv
// rtl/parity_frame_tx.sv - serial frame transmitter: start, data LSB first, parity, stop
module parity_frame_tx
    import parity_frame_pkg::*;
#(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    input  logic              mode,
    output logic              in_ready,
    output logic              tx,
    output logic              busy,
    output logic              frame_done
);

    localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [TW-1:0] T_LAST = TW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] B_LAST = BW'(DATA_W - 1);

    state_e              state_q;
    logic [TW-1:0]       timer_q;
    logic [BW-1:0]       bit_idx_q;
    logic [DATA_W-1:0]   shift_q;
    logic                parity_q;
    logic                tx_q;
    logic                in_ready_q;
    logic                busy_q;
    logic                frame_done_q;

    logic                calc_parity;
    logic                timer_done;
    logic                stop_penult;
    logic [DATA_W-1:0]   shift_d;

    parity_calc #(.DATA_W(DATA_W)) u_parity_calc (
        .data_i   (in_data),
        .mode_i   (mode),
        .parity_o (calc_parity)
    );

    assign timer_done  = (timer_q == T_LAST);
    // Next cycle is the last one of the stop bit, so the pulse lands in it.
    assign stop_penult = ((int'(timer_q) + 2) == CLKS_PER_BIT);
    assign shift_d     = shift_q >> 1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            timer_q      <= '0;
            bit_idx_q    <= '0;
            shift_q      <= '0;
            parity_q     <= 1'b0;
            tx_q         <= 1'b1;
            in_ready_q   <= 1'b1;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    frame_done_q <= 1'b0;
                    if (in_valid && in_ready_q) begin
                        shift_q    <= in_data;
                        parity_q   <= calc_parity;
                        timer_q    <= '0;
                        state_q    <= ST_START;
                        tx_q       <= 1'b0;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                    end
                end
                ST_START: begin
                    if (timer_done) begin
                        timer_q   <= '0;
                        bit_idx_q <= '0;
                        state_q   <= ST_DATA;
                        tx_q      <= shift_q[0];
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (timer_done) begin
                        timer_q <= '0;
                        if (bit_idx_q == B_LAST) begin
                            state_q <= ST_PARITY;
                            tx_q    <= parity_q;
                        end else begin
                            bit_idx_q <= bit_idx_q + 1'b1;
                            shift_q   <= shift_d;
                            tx_q      <= shift_d[0];
                        end
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                end
                ST_PARITY: begin
                    if (timer_done) begin
                        timer_q      <= '0;
                        state_q      <= ST_STOP;
                        tx_q         <= 1'b1;
                        frame_done_q <= (CLKS_PER_BIT == 1);
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                end
                ST_STOP: begin
                    if (timer_done) begin
                        timer_q      <= '0;
                        state_q      <= ST_IDLE;
                        frame_done_q <= 1'b0;
                        in_ready_q   <= 1'b1;
                        busy_q       <= 1'b0;
                    end else begin
                        timer_q      <= timer_q + 1'b1;
                        frame_done_q <= stop_penult;
                    end
                end
                default: begin
                    state_q      <= ST_IDLE;
                    timer_q      <= '0;
                    tx_q         <= 1'b1;
                    in_ready_q   <= 1'b1;
                    busy_q       <= 1'b0;
                    frame_done_q <= 1'b0;
                end
            endcase
        end
    end

    assign tx         = tx_q;
    assign in_ready   = in_ready_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_parity_frame_tx.sv
// tb/tb_parity_frame_tx.sv - self-checking bench for parity_frame_tx
module tb_parity_frame_tx;

    logic       clk;
    logic       rst;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_valid1;
    logic       mode;
    logic       in_ready, tx, busy, frame_done;
    logic       in_ready1, tx1, busy1, frame_done1;

    int n_tests;
    int n_fail;

    parity_frame_tx #(.DATA_W(8), .CLKS_PER_BIT(4)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .mode(mode),
        .in_ready(in_ready), .tx(tx), .busy(busy), .frame_done(frame_done)
    );

    parity_frame_tx #(.DATA_W(8), .CLKS_PER_BIT(1)) dut1 (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid1), .mode(mode),
        .in_ready(in_ready1), .tx(tx1), .busy(busy1), .frame_done(frame_done1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        logic       mode;
        logic       par;
    } vec_t;

    vec_t tbl[5];

    // Observed outputs packed as {tx, frame_done, busy, in_ready}.
    function automatic logic [3:0] obs(input int cpb);
        if (cpb == 1) return {tx1, frame_done1, busy1, in_ready1};
        return {tx, frame_done, busy, in_ready};
    endfunction

    function automatic logic model_parity(input logic [7:0] d, input logic m);
        return (($countones(d) % 2) == 1) ^ m;
    endfunction

    // Serial bit sequence: start 0, data LSB first, parity, stop 1.
    function automatic logic model_bit(input logic [7:0] d, input logic par, input int k, input int cpb);
        int idx;
        idx = (k - 1) / cpb;
        if (idx == 0) return 1'b0;
        if (idx <= 8) return d[idx-1];
        if (idx == 9) return par;
        return 1'b1;
    endfunction

    task automatic check(input string name, input int k, input logic [3:0] act, input logic [3:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got {tx,done,busy,ready}=%b expected %b", name, k, act, exp);
        end
    endtask

    task automatic set_valid(input int cpb, input logic v);
        if (cpb == 1) in_valid1 = v;
        else in_valid = v;
    endtask

    task automatic present(input logic [7:0] d, input logic m, input int cpb);
        in_data = d;
        mode    = m;
        set_valid(cpb, 1'b1);
    endtask

    task automatic run_frame(input logic [7:0] d, input logic m, input int cpb, input int toggle_at,
                             input bit keep_valid, input logic [7:0] next_d, input int exp_par);
        int   len;
        logic par;
        len = 11 * cpb;
        par = model_parity(d, m);
        for (int k = 1; k <= len; k++) begin
            @(negedge clk);
            if (k == 1) begin
                if (keep_valid) in_data = next_d;
                else begin
                    set_valid(cpb, 1'b0);
                    in_data = 8'($urandom);
                end
            end
            if (k == toggle_at) mode = ~mode;
            check("frame", k, obs(cpb), {model_bit(d, par, k, cpb), (k == len), 1'b1, 1'b0});
            if (exp_par >= 0 && k == 9 * cpb + 1) begin
                n_tests++;
                if (obs(cpb)[3] !== exp_par[0]) begin
                    n_fail++;
                    $display("FAIL parity_bit data=%h mode=%0d: got %b expected %0d", d, m, obs(cpb)[3], exp_par);
                end
            end
        end
        @(negedge clk);
        check("idle_after", len + 1, obs(cpb), 4'b1001);
    endtask

    initial begin
        logic [7:0] d;
        logic       m;
        logic       par;

        n_tests   = 0;
        n_fail    = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_valid1 = 1'b0;
        in_data   = 8'h00;
        mode      = 1'b0;

        tbl[0] = '{8'b01010101, 1'b0, 1'b0};
        tbl[1] = '{8'b01010101, 1'b1, 1'b1};
        tbl[2] = '{8'b11111110, 1'b0, 1'b1};
        tbl[3] = '{8'b00110001, 1'b0, 1'b1};
        tbl[4] = '{8'b00000000, 1'b1, 1'b1};

        repeat (3) @(negedge clk);
        check("reset_held", 0, obs(4), 4'b1001);
        check("reset_held_cpb1", 0, obs(1), 4'b1001);
        rst = 1'b0;
        @(negedge clk);
        check("reset_released", 0, obs(4), 4'b1001);
        check("reset_released_cpb1", 0, obs(1), 4'b1001);

        for (int i = 0; i < 5; i++) begin
            present(tbl[i].data, tbl[i].mode, 4);
            run_frame(tbl[i].data, tbl[i].mode, 4, -1, 1'b0, 8'h00, int'(tbl[i].par));
        end

        present(8'b00110101, 1'b0, 4);
        run_frame(8'b00110101, 1'b0, 4, 10, 1'b0, 8'h00, 0);

        present(8'h55, 1'b0, 4);
        run_frame(8'h55, 1'b0, 4, -1, 1'b1, 8'hCC, -1);
        run_frame(8'hCC, 1'b0, 4, -1, 1'b0, 8'h00, 0);

        for (int i = 0; i < 10; i++) begin
            d = 8'($urandom);
            m = 1'($urandom_range(0, 1));
            present(d, m, 4);
            run_frame(d, m, 4, int'($urandom_range(2, 44)), 1'b0, 8'h00, -1);
        end

        d   = 8'hA7;
        m   = 1'b1;
        par = model_parity(d, m);
        present(d, m, 4);
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (k == 1) in_valid = 1'b0;
            check("pre_reset", k, obs(4), {model_bit(d, par, k, 4), 1'b0, 1'b1, 1'b0});
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("reset_mid", 21, obs(4), 4'b1001);
        for (int k = 22; k < 28; k++) begin
            @(negedge clk);
            check("post_reset_idle", k, obs(4), 4'b1001);
        end
        present(8'h3C, 1'b1, 4);
        run_frame(8'h3C, 1'b1, 4, -1, 1'b0, 8'h00, 1);

        present(8'hFF, 1'b1, 1);
        run_frame(8'hFF, 1'b1, 1, -1, 1'b0, 8'h00, 1);
        for (int i = 0; i < 6; i++) begin
            d = 8'($urandom);
            m = 1'($urandom_range(0, 1));
            present(d, m, 1);
            run_frame(d, m, 1, -1, 1'b0, 8'h00, int'(model_parity(d, m)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
